matrix_operand_sequencer: RTL and testbench

// Sequential operand fetch unit for the matrix multiplier datapath.
// - On start, walks the i/j/k loop nest of C = A x B internally.
// - Each beat presents LANES consecutive A[i][k..] / B[k..][j] element pairs to the MAC stage.
// - Handshake is valid/ready; first_k/last_k markers delimit each C[i][j] accumulation.
// - Replaces externally driven i/j/k indexing with a self-timed, back-pressurable stream.

---
 rtl/matrix_pkg.sv | 15 +
 rtl/matrix_index_counter.sv | 80 ++++++++
 rtl/matrix_operand_sequencer.sv | 161 ++++++++++++++++
 tb/tb_matrix_operand_sequencer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix operand sequencer.
package matrix_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } seq_state_t;

   // Index width for a loop of n iterations; one spare bit keeps n itself representable.
   function automatic int unsigned idx_w(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Nested i/j/k loop counter. k advances by STRIDE, j on k wrap, i on j wrap.
// Wraps back to (0,0,0) after the final position so the next sweep starts clean.
module matrix_index_counter
   import matrix_pkg::*;
#(
   parameter int unsigned NI     = 3,
   parameter int unsigned NJ     = 3,
   parameter int unsigned NK     = 3,
   parameter int unsigned STRIDE = 1
) (
   input  logic                    clock,
   input  logic                    nreset,
   input  logic                    step,
   input  logic                    clear,
   output logic [idx_w(NI)-1:0]    i,
   output logic [idx_w(NJ)-1:0]    j,
   output logic [idx_w(NK)-1:0]    k,
   output logic                    first_k,
   output logic                    last_k,
   output logic                    wrap_all
);

   localparam int unsigned IW = idx_w(NI);
   localparam int unsigned JW = idx_w(NJ);
   localparam int unsigned KW = idx_w(NK);

   logic [IW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [KW-1:0] k_q, k_d;
   logic          last_j;
   logic          last_i;

   assign first_k  = (k_q == '0);
   assign last_k   = (k_q == KW'(NK - STRIDE));
   assign last_j   = (j_q == JW'(NJ - 1));
   assign last_i   = (i_q == IW'(NI - 1));
   assign wrap_all = last_k && last_j && last_i;

   assign i = i_q;
   assign j = j_q;
   assign k = k_q;

   // Next index: clear has priority, otherwise carry k -> j -> i on step
   always_comb begin
      i_d = i_q;
      j_d = j_q;
      k_d = k_q;
      if (clear) begin
         i_d = '0;
         j_d = '0;
         k_d = '0;
      end else if (step) begin
         if (last_k) begin
            k_d = '0;
            if (last_j) begin
               j_d = '0;
               i_d = last_i ? '0 : i_q + IW'(1);
            end else begin
               j_d = j_q + JW'(1);
            end
         end else begin
            k_d = k_q + KW'(STRIDE);
         end
      end
   end

   // Index registers
   always_ff @(posedge clock) begin
      if (!nreset) begin
         i_q <= '0;
         j_q <= '0;
         k_q <= '0;
      end else begin
         i_q <= i_d;
         j_q <= j_d;
         k_q <= k_d;
      end
   end

endmodule

// File: rtl/matrix_operand_sequencer.sv
// Self-timed operand stream for C = A x B. Each beat carries LANES consecutive
// A[i][k..] / B[k..][j] pairs; first_k/last_k frame each C[i][j] accumulation.
// The index counter points at the beat to be loaded next, so the output
// registers can be refilled on the same edge a beat is accepted (no bubbles).
module matrix_operand_sequencer
   import matrix_pkg::*;
#(
   parameter int unsigned AROWS     = 3,
   parameter int unsigned ACOLUMNS  = 3,
   parameter int unsigned BCOLUMNS  = 3,
   parameter int unsigned WIDTH_BIT = 32,
   parameter int unsigned LANES     = 1
) (
   input  logic                          clock,
   input  logic                          nreset,
   input  logic                          start,
   input  logic signed [WIDTH_BIT-1:0]   MatrixA [AROWS][ACOLUMNS],
   input  logic signed [WIDTH_BIT-1:0]   MatrixB [ACOLUMNS][BCOLUMNS],
   output logic signed [WIDTH_BIT-1:0]   a_vec [LANES],
   output logic signed [WIDTH_BIT-1:0]   b_vec [LANES],
   output logic [idx_w(AROWS)-1:0]       i_out,
   output logic [idx_w(BCOLUMNS)-1:0]    j_out,
   output logic                          first_k,
   output logic                          last_k,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned IW = idx_w(AROWS);
   localparam int unsigned JW = idx_w(BCOLUMNS);
   localparam int unsigned KW = idx_w(ACOLUMNS);

   seq_state_t state_q, state_d;
   logic       load;
   logic       clear;
   logic       last_beat_q;

   logic [IW-1:0] cnt_i;
   logic [JW-1:0] cnt_j;
   logic [KW-1:0] cnt_k;
   logic          cnt_first;
   logic          cnt_last;
   logic          cnt_wrap;

   logic signed [WIDTH_BIT-1:0] a_d [LANES];
   logic signed [WIDTH_BIT-1:0] b_d [LANES];

   matrix_index_counter #(
      .NI     (AROWS),
      .NJ     (BCOLUMNS),
      .NK     (ACOLUMNS),
      .STRIDE (LANES)
   ) u_counter (
      .clock    (clock),
      .nreset   (nreset),
      .step     (load),
      .clear    (clear),
      .i        (cnt_i),
      .j        (cnt_j),
      .k        (cnt_k),
      .first_k  (cnt_first),
      .last_k   (cnt_last),
      .wrap_all (cnt_wrap)
   );

   // FSM state register
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state; load presents a new beat and advances the counter
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      clear   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (out_ready) begin
               if (last_beat_q) begin
                  state_d = DONE;
               end else begin
                  load = 1'b1;
               end
            end
         end
         DONE: begin
            clear   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Lane l selects A[i][k+l] and B[k+l][j] for the beat about to be loaded
   always_comb begin
      for (int l = 0; l < int'(LANES); l++) begin
         a_d[l] = '0;
         b_d[l] = '0;
      end
      for (int r = 0; r < int'(AROWS); r++) begin
         for (int c = 0; c < int'(ACOLUMNS); c++) begin
            for (int l = 0; l < int'(LANES); l++) begin
               if ((int'(cnt_i) == r) && (int'(cnt_k) + l == c)) begin
                  a_d[l] = MatrixA[r][c];
               end
            end
         end
      end
      for (int r = 0; r < int'(ACOLUMNS); r++) begin
         for (int c = 0; c < int'(BCOLUMNS); c++) begin
            for (int l = 0; l < int'(LANES); l++) begin
               if ((int'(cnt_k) + l == r) && (int'(cnt_j) == c)) begin
                  b_d[l] = MatrixB[r][c];
               end
            end
         end
      end
   end

   // Output register stage; holds while a beat waits for out_ready
   always_ff @(posedge clock) begin
      if (!nreset) begin
         for (int l = 0; l < int'(LANES); l++) begin
            a_vec[l] <= '0;
            b_vec[l] <= '0;
         end
         i_out       <= '0;
         j_out       <= '0;
         first_k     <= 1'b0;
         last_k      <= 1'b0;
         last_beat_q <= 1'b0;
      end else if (load) begin
         for (int l = 0; l < int'(LANES); l++) begin
            a_vec[l] <= a_d[l];
            b_vec[l] <= b_d[l];
         end
         i_out       <= cnt_i;
         j_out       <= cnt_j;
         first_k     <= cnt_first;
         last_k      <= cnt_last;
         last_beat_q <= cnt_wrap;
      end
   end

   assign out_valid = (state_q == RUN);
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Bench for matrix_operand_sequencer: three instances (3x3x3/L1, 2x4x3/L2, 3x3x3/L3)
// driven one at a time; accepted beats are compared with a reference stream
// computed directly from the loop-nest definition.
module tb_matrix_operand_sequencer;

   typedef struct packed {
      logic [7:0]       i;
      logic [7:0]       j;
      logic             f;
      logic             l;
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
   } beat_t;

   typedef struct {
      int sel;
      bit det;
      int stall_at;
      int start_at;
      int reset_at;
      bit rnd;
      int exp_beats;
   } scen_t;

   typedef struct {
      int scen;
      int beat;
      int i;
      int j;
      bit f;
      bit l;
      int a0;
      int a1;
      int b0;
      int b1;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   logic nreset;
   logic st;
   logic rd;
   int   sel;
   int   ra [4][4];
   int   rb [4][4];

   int n_checks = 0;
   int n_errors = 0;

   int dna [3] = '{3, 2, 3};
   int dnk [3] = '{3, 4, 3};
   int dnb [3] = '{3, 3, 3};
   int dl  [3] = '{1, 2, 3};

   logic signed [31:0] ma0 [3][3];
   logic signed [31:0] mb0 [3][3];
   logic signed [31:0] ma1 [2][4];
   logic signed [31:0] mb1 [4][3];
   logic signed [31:0] ma2 [3][3];
   logic signed [31:0] mb2 [3][3];

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            ma0[r][c] = ra[r][c];
            mb0[r][c] = rb[r][c];
            ma2[r][c] = ra[r][c];
            mb2[r][c] = rb[r][c];
         end
      end
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) begin
            ma1[r][c] = ra[r][c];
         end
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            mb1[r][c] = rb[r][c];
         end
      end
   end

   logic st0, st1, st2, rd0, rd1, rd2;
   assign st0 = st && (sel == 0);
   assign st1 = st && (sel == 1);
   assign st2 = st && (sel == 2);
   assign rd0 = rd && (sel == 0);
   assign rd1 = rd && (sel == 1);
   assign rd2 = rd && (sel == 2);

   logic signed [31:0] av0 [1];
   logic signed [31:0] bv0 [1];
   logic signed [31:0] av1 [2];
   logic signed [31:0] bv1 [2];
   logic signed [31:0] av2 [3];
   logic signed [31:0] bv2 [3];
   logic [2:0] i0, j0, j1, i2, j2;
   logic [1:0] i1;
   logic f0, l0, v0, b0, d0;
   logic f1, l1, v1, b1, d1;
   logic f2, l2, v2, b2, d2;

   matrix_operand_sequencer #(
      .AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3), .WIDTH_BIT(32), .LANES(1)
   ) u0 (
      .clock(clock), .nreset(nreset), .start(st0), .MatrixA(ma0), .MatrixB(mb0),
      .a_vec(av0), .b_vec(bv0), .i_out(i0), .j_out(j0), .first_k(f0), .last_k(l0),
      .out_valid(v0), .out_ready(rd0), .busy(b0), .done(d0)
   );

   matrix_operand_sequencer #(
      .AROWS(2), .ACOLUMNS(4), .BCOLUMNS(3), .WIDTH_BIT(32), .LANES(2)
   ) u1 (
      .clock(clock), .nreset(nreset), .start(st1), .MatrixA(ma1), .MatrixB(mb1),
      .a_vec(av1), .b_vec(bv1), .i_out(i1), .j_out(j1), .first_k(f1), .last_k(l1),
      .out_valid(v1), .out_ready(rd1), .busy(b1), .done(d1)
   );

   matrix_operand_sequencer #(
      .AROWS(3), .ACOLUMNS(3), .BCOLUMNS(3), .WIDTH_BIT(32), .LANES(3)
   ) u2 (
      .clock(clock), .nreset(nreset), .start(st2), .MatrixA(ma2), .MatrixB(mb2),
      .a_vec(av2), .b_vec(bv2), .i_out(i2), .j_out(j2), .first_k(f2), .last_k(l2),
      .out_valid(v2), .out_ready(rd2), .busy(b2), .done(d2)
   );

   // View of the selected instance
   logic             m_v, m_bz, m_d, m_f, m_l, m_rd;
   logic [7:0]       m_i, m_j;
   logic [3:0][31:0] m_a, m_b;

   always_comb begin
      m_a = '0;
      m_b = '0;
      case (sel)
         0: begin
            m_v = v0; m_bz = b0; m_d = d0; m_f = f0; m_l = l0; m_rd = rd0;
            m_i = 8'(i0); m_j = 8'(j0);
            m_a[0] = av0[0]; m_b[0] = bv0[0];
         end
         1: begin
            m_v = v1; m_bz = b1; m_d = d1; m_f = f1; m_l = l1; m_rd = rd1;
            m_i = 8'(i1); m_j = 8'(j1);
            m_a[0] = av1[0]; m_a[1] = av1[1];
            m_b[0] = bv1[0]; m_b[1] = bv1[1];
         end
         default: begin
            m_v = v2; m_bz = b2; m_d = d2; m_f = f2; m_l = l2; m_rd = rd2;
            m_i = 8'(i2); m_j = 8'(j2);
            m_a[0] = av2[0]; m_a[1] = av2[1]; m_a[2] = av2[2];
            m_b[0] = bv2[0]; m_b[1] = bv2[1]; m_b[2] = bv2[2];
         end
      endcase
   end

   beat_t q [$];
   int    qc [$];
   int    dn;
   int    dcyc;
   int    st_cyc;

   scen_t sc_tab [10];
   vec_t  vt [6];

   task automatic chk(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic chk_beat(input string name, input beat_t act, input beat_t req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got i=%0d j=%0d f=%0b l=%0b a=%h b=%h, required i=%0d j=%0d f=%0b l=%0b a=%h b=%h",
                  name, act.i, act.j, act.f, act.l, act.a, act.b,
                  req.i, req.j, req.f, req.l, req.a, req.b);
      end
   endtask

   function automatic beat_t sample_now();
      beat_t t;
      t   = '0;
      t.i = m_i;
      t.j = m_j;
      t.f = m_f;
      t.l = m_l;
      t.a = m_a;
      t.b = m_b;
      return t;
   endfunction

   // Beat n of the sweep: k runs fastest in strides of L, then j, then i
   function automatic beat_t model_beat(input int n, input int s);
      beat_t t;
      int    per, k, ij;
      per = dnk[s] / dl[s];
      k   = (n % per) * dl[s];
      ij  = n / per;
      t   = '0;
      t.i = 8'(ij / dnb[s]);
      t.j = 8'(ij % dnb[s]);
      t.f = (k == 0);
      t.l = (k + dl[s] == dnk[s]);
      for (int l = 0; l < dl[s]; l++) begin
         t.a[l] = ra[ij / dnb[s]][k + l];
         t.b[l] = rb[k + l][ij % dnb[s]];
      end
      return t;
   endfunction

   task automatic run_sweep(input int s);
      scen_t sc;
      beat_t t, prev;
      bit    prev_stall, finished, aborted, pulsed;
      int    stall_n, guard, post, last;
      sc = sc_tab[s];
      sel = sc.sel;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ra[r][c] = sc.det ? 10 * r + c : int'($urandom);
            rb[r][c] = sc.det ? 100 + 10 * r + c : int'($urandom);
         end
      end
      q.delete();
      qc.delete();
      dn = 0; dcyc = 0;
      prev = '0; prev_stall = 0; finished = 0; aborted = 0; pulsed = 0;
      stall_n = 0; guard = 0; post = 0;
      rd = 1'b1;
      st = 1'b1;
      @(posedge clock); #1;
      st = 1'b0;
      st_cyc = cyc;
      while (!finished && guard < 400) begin
         if (q.size() == sc.reset_at) begin
            nreset = 1'b0;
            @(posedge clock); #1;
            chk($sformatf("s%0d_abort_valid", s), m_v, 0);
            chk($sformatf("s%0d_abort_busy", s), m_bz, 0);
            chk($sformatf("s%0d_abort_done", s), m_d, 0);
            nreset = 1'b1;
            aborted = 1;
            break;
         end
         if (q.size() == sc.stall_at && stall_n < 3) begin
            rd = 1'b0;
            stall_n++;
         end else if (sc.rnd) begin
            rd = ($urandom_range(0, 3) != 0);
         end else begin
            rd = 1'b1;
         end
         if (q.size() == sc.start_at && !pulsed) begin
            st = 1'b1;
            pulsed = 1;
         end else begin
            st = 1'b0;
         end
         @(negedge clock);
         t = sample_now();
         if (prev_stall) begin
            chk($sformatf("s%0d_stall_valid", s), m_v, 1);
            chk_beat($sformatf("s%0d_stall_hold", s), t, prev);
         end
         if (m_v && m_rd) begin
            q.push_back(t);
            qc.push_back(cyc);
         end
         if (m_d) begin
            dn++;
            dcyc = cyc;
         end
         prev_stall = m_v && !m_rd;
         prev = t;
         if (dn > 0) post++;
         if (post >= 3) finished = 1;
         @(posedge clock); #1;
         guard++;
      end
      st = 1'b0;
      if (aborted) begin
         repeat (3) begin
            @(negedge clock);
            if (m_d) dn++;
         end
         chk($sformatf("s%0d_abort_no_done", s), dn, 0);
         @(posedge clock); #1;
      end else begin
         chk($sformatf("s%0d_timeout", s), finished, 1);
         chk($sformatf("s%0d_beats", s), q.size(), sc.exp_beats);
         chk($sformatf("s%0d_done_count", s), dn, 1);
         for (int n = 0; n < q.size() && n < sc.exp_beats; n++) begin
            chk_beat($sformatf("s%0d_beat%0d", s, n), q[n], model_beat(n, sc.sel));
         end
         if (q.size() > 0) begin
            last = q.size() - 1;
            chk($sformatf("s%0d_done_cycle", s), dcyc, qc[last] + 1);
            if (!sc.rnd && sc.stall_at < 0) begin
               chk($sformatf("s%0d_first_latency", s), qc[0], st_cyc);
               chk($sformatf("s%0d_no_bubbles", s), qc[last], st_cyc + sc.exp_beats - 1);
            end
         end
      end
      for (int v = 0; v < 6; v++) begin
         if (vt[v].scen == s) begin
            beat_t e;
            e = '0;
            e.i = 8'(vt[v].i);
            e.j = 8'(vt[v].j);
            e.f = vt[v].f;
            e.l = vt[v].l;
            e.a[0] = vt[v].a0; e.a[1] = vt[v].a1;
            e.b[0] = vt[v].b0; e.b[1] = vt[v].b1;
            if (vt[v].beat < q.size()) begin
               chk_beat($sformatf("s%0d_vec_beat%0d", s, vt[v].beat), q[vt[v].beat], e);
            end else begin
               chk($sformatf("s%0d_vec_beat%0d_present", s, vt[v].beat), q.size(), vt[v].beat + 1);
            end
         end
      end
   endtask

   initial begin
      //             sel det stall start reset rnd beats
      sc_tab[0] = '{0, 1, -1, -1, -1, 0, 27};
      sc_tab[1] = '{0, 1,  5, -1, -1, 0, 27};
      sc_tab[2] = '{1, 1, -1, -1, -1, 0, 12};
      sc_tab[3] = '{2, 1, -1, -1, -1, 0,  9};
      sc_tab[4] = '{0, 0, -1,  4, -1, 0, 27};
      sc_tab[5] = '{0, 0, -1, -1, -1, 1, 27};
      sc_tab[6] = '{1, 0, -1, -1, -1, 1, 12};
      sc_tab[7] = '{2, 0, -1, -1, -1, 1,  9};
      sc_tab[8] = '{0, 1, -1, -1, 10, 0, 27};
      sc_tab[9] = '{0, 1, -1, -1, -1, 0, 27};

      //          scen beat i  j  f  l  a0  a1  b0   b1
      vt[0] = '{0,  0, 0, 0, 1, 0,  0,  0, 100,   0};
      vt[1] = '{0,  2, 0, 0, 0, 1,  2,  0, 120,   0};
      vt[2] = '{0, 26, 2, 2, 0, 1, 22,  0, 122,   0};
      vt[3] = '{1,  5, 0, 1, 0, 1,  2,  0, 121,   0};
      vt[4] = '{2,  1, 0, 0, 0, 1,  2,  3, 120, 130};
      vt[5] = '{9,  0, 0, 0, 1, 0,  0,  0, 100,   0};

      nreset = 1'b0;
      st = 1'b0;
      rd = 1'b0;
      sel = 0;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            ra[r][c] = 10 * r + c + 1;
            rb[r][c] = 100 + 10 * r + c;
         end
      end
      repeat (3) @(posedge clock);
      #1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk($sformatf("rst%0d_valid", s), m_v, 0);
         chk($sformatf("rst%0d_busy", s), m_bz, 0);
         chk($sformatf("rst%0d_done", s), m_d, 0);
         chk($sformatf("rst%0d_first_last", s), {m_f, m_l}, 0);
         chk($sformatf("rst%0d_ij", s), {m_i, m_j}, 0);
         chk($sformatf("rst%0d_a_lane0", s), m_a[0], 0);
         chk($sformatf("rst%0d_b_lane0", s), m_b[0], 0);
      end
      nreset = 1'b1;
      @(posedge clock); #1;

      for (int s = 0; s < 10; s++) begin
         run_sweep(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
